// File: rtl/ifu_fetch_if.sv
// Instruction bus between the fetch unit (master) and instruction memory (slave).
// One request in flight at a time: req/gnt address phase, rvalid/rdata response.
interface ifu_fetch_if;
  logic        ibus_req_o;
  logic [31:0] ibus_addr_o;
  logic        ibus_gnt_i;
  logic        ibus_rvalid_i;
  logic [31:0] ibus_rdata_i;

  modport master (
    output ibus_req_o,
    output ibus_addr_o,
    input  ibus_gnt_i,
    input  ibus_rvalid_i,
    input  ibus_rdata_i
  );

  modport slave (
    input  ibus_req_o,
    input  ibus_addr_o,
    output ibus_gnt_i,
    output ibus_rvalid_i,
    output ibus_rdata_i
  );
endinterface

// File: rtl/ifu_fetch.sv
// Fetch unit: owns the fetch PC, buffers returned words in a prefetch FIFO, predecodes the head for bpu.
// Optional macro IFU_BYPASS_EN: present a response to decode in its arrival cycle when the FIFO is empty.
module ifu_fetch #(
  parameter logic [31:0] REBOOT_ADDR = 32'h0000_0000,
  parameter int          FIFO_DEPTH  = 2,
  parameter logic [31:0] INST_NOP    = 32'h0000_0013
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               hold_i,
  input  logic               flush_i,
  input  logic [31:0]        flush_addr_i,
  ifu_fetch_if.master        ibus,
  output logic [31:0]        bpu_pc_o,
  output logic               bpu_inst_jal_o,
  output logic               bpu_inst_jalr_o,
  output logic               bpu_inst_bxx_o,
  output logic [31:0]        bpu_imm_o,
  input  logic               prdt_taken_i,
  input  logic [31:0]        prdt_addr_i,
  output logic               inst_valid_o,
  input  logic               inst_ready_i,
  output logic [31:0]        inst_o,
  output logic [31:0]        inst_addr_o,
  output logic               prdt_taken_o
);

  localparam int               PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int               CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [6:0]       OP_JAL  = 7'b1101111;
  localparam logic [6:0]       OP_JALR = 7'b1100111;
  localparam logic [6:0]       OP_BXX  = 7'b1100011;

  typedef enum logic [0:0] {S_REQ = 1'b0, S_WAIT = 1'b1} state_t;

  state_t            r_state;
  logic [31:0]       r_fetch_pc;
  logic [31:0]       r_req_pc;
  logic              r_drop;
  logic [31:0]       r_pc_q   [FIFO_DEPTH];
  logic [31:0]       r_inst_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_count;

  logic              w_fifo_empty;
  logic              w_resp_ok;
  logic              w_byp;
  logic              w_head_avail;
  logic [31:0]       w_head_pc;
  logic [31:0]       w_head_inst;
  logic              w_pop;
  logic              w_fifo_pop;
  logic              w_bpu_redir;
  logic              w_redirect;
  logic              w_req;
  logic              w_grant;
  logic              w_push;

  function automatic logic [31:0] f_imm(input logic [31:0] inst);
    logic [31:0] imm;
    case (inst[6:0])
      OP_JAL:  imm = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
      OP_BXX:  imm = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
      OP_JALR: imm = {{20{inst[31]}}, inst[31:20]};
      default: imm = 32'h0000_0000;
    endcase
    return imm;
  endfunction

  assign w_fifo_empty = (r_count == {CNT_W{1'b0}});
  assign w_resp_ok    = (r_state == S_WAIT) & ibus.ibus_rvalid_i & ~r_drop;

`ifdef IFU_BYPASS_EN
  assign w_byp = w_resp_ok & w_fifo_empty;
`else
  assign w_byp = 1'b0;
`endif

  assign w_head_avail = ~w_fifo_empty | w_byp;
  assign w_head_pc    = w_byp ? r_req_pc           : r_pc_q[r_rptr];
  assign w_head_inst  = w_byp ? ibus.ibus_rdata_i  : r_inst_q[r_rptr];

  assign inst_valid_o = w_head_avail & ~flush_i;
  assign w_pop        = inst_valid_o & inst_ready_i;
  assign w_fifo_pop   = w_pop & ~w_byp;
  assign w_bpu_redir  = w_pop & prdt_taken_i;
  assign w_redirect   = flush_i | w_bpu_redir;

  // Only one request is ever in flight, so in S_REQ the FIFO count alone bounds occupancy.
  assign w_req   = rst & (r_state == S_REQ) & ~hold_i & ~w_redirect & (r_count < DEPTH_C);
  assign w_grant = w_req & ibus.ibus_gnt_i;
  assign w_push  = w_resp_ok & ~w_redirect & ~(w_byp & w_pop);

  assign ibus.ibus_req_o  = w_req;
  assign ibus.ibus_addr_o = {r_fetch_pc[31:2], 2'b00};

  assign inst_o       = inst_valid_o ? w_head_inst : INST_NOP;
  assign inst_addr_o  = inst_valid_o ? w_head_pc   : 32'h0000_0000;
  assign prdt_taken_o = prdt_taken_i & inst_valid_o;

  assign bpu_pc_o        = w_head_avail ? w_head_pc : 32'h0000_0000;
  assign bpu_inst_jal_o  = w_head_avail & (w_head_inst[6:0] == OP_JAL);
  assign bpu_inst_jalr_o = w_head_avail & (w_head_inst[6:0] == OP_JALR);
  assign bpu_inst_bxx_o  = w_head_avail & (w_head_inst[6:0] == OP_BXX);
  assign bpu_imm_o       = w_head_avail ? f_imm(w_head_inst) : 32'h0000_0000;

  // Fetch FSM: a redirect while waiting leaves the response to be swallowed via r_drop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_REQ;
      r_fetch_pc <= REBOOT_ADDR;
      r_req_pc   <= 32'h0000_0000;
      r_drop     <= 1'b0;
    end else begin
      case (r_state)
        S_REQ: begin
          if (w_grant) begin
            r_req_pc   <= r_fetch_pc;
            r_fetch_pc <= r_fetch_pc + 32'd4;
            r_state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (ibus.ibus_rvalid_i) begin
            r_drop  <= 1'b0;
            r_state <= S_REQ;
          end else if (w_redirect) begin
            r_drop  <= 1'b1;
          end
        end
        default: r_state <= S_REQ;
      endcase
      if (w_redirect) begin
        r_fetch_pc <= flush_i ? flush_addr_i : prdt_addr_i;
      end
    end
  end

  // Prefetch FIFO; any redirect discards every buffered (younger) entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_pc_q[i]   <= 32'h0000_0000;
        r_inst_q[i] <= 32'h0000_0000;
      end
    end else if (w_redirect) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_pc_q[r_wptr]   <= r_req_pc;
        r_inst_q[r_wptr] <= ibus.ibus_rdata_i;
        r_wptr           <= r_wptr + PTR_W'(1);
      end
      if (w_fifo_pop) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_fifo_pop);
    end
  end

endmodule
